// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 pixel-buffer write path.
// The timing constants are 50 MHz cycle counts used by the serial driver.
package ws2812_pkg;

  localparam int RGB_W = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int T0H_CYCLES   = 20;
  localparam int T0L_CYCLES   = 43;
  localparam int T1H_CYCLES   = 40;
  localparam int T1L_CYCLES   = 22;
  localparam int RESET_CYCLES = 2500;

  // Each channel becomes (c * (b + 1)) >> 8, so b = 255 leaves the colour unchanged.
  function automatic rgb_t scale_rgb(input rgb_t c, input logic [7:0] b);
    rgb_t        r;
    logic [15:0] p;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      p = 16'(c[k*8 +: 8]) * (16'(b) + 16'd1);
      r[k*8 +: 8] = p[15:8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ws2812_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr_i, and the pointer then moves
// to the slot just after the winner.
module ws2812_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PW-1:0]      next_ptr_o
);

  int idx;

  // The scan runs from the farthest slot back to ptr_i, so the closest requester wins.
  always_comb begin
    grant_o    = '0;
    next_ptr_o = ptr_i;
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        next_ptr_o   = PW'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/ws2812_write_scheduler.sv
// Shares the WS2812 buffer write port between round-robin requesters and a range-fill engine.
// Defining WS2812_BRIGHTNESS_EN adds a brightness-scaling stage, which raises write latency to 2.
module ws2812_write_scheduler
  import ws2812_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*RGB_W-1:0]  req_rgb,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fill_start,
  input  logic [RGB_W-1:0]          fill_rgb,
  input  logic [ADDR_W:0]           fill_count,
  output logic                      fill_busy,
  output logic                      fill_done,
  input  logic [7:0]                brightness,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [RGB_W-1:0]          wr_rgb
);

  localparam int PW = $clog2(NUM_REQ);

  sched_state_t        state_q;
  logic [PW-1:0]       ptr_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     count_q;
  rgb_t                fill_rgb_q;
  logic                fill_busy_q;
  logic                fill_done_q;
  logic                s1_en_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  rgb_t                s1_rgb_q;

  logic [NUM_REQ-1:0]  grant;
  logic [PW-1:0]       next_ptr;
  logic [ADDR_W-1:0]   sel_addr;
  rgb_t                sel_rgb;
  logic                arb_en;

  ws2812_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .req_i      (req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .next_ptr_o (next_ptr)
  );

  // A fill request takes priority, and reset masks grants right away.
  assign arb_en    = rst_n && (state_q == IDLE) && !fill_start;
  assign req_ready = arb_en ? grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_rgb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_rgb  = req_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      count_q     <= '0;
      fill_rgb_q  <= '0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_addr_q   <= '0;
      s1_rgb_q    <= '0;
    end else begin
      s1_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fill_start) begin
            fill_rgb_q  <= fill_rgb;
            count_q     <= fill_count;
            cnt_q       <= '0;
            fill_busy_q <= 1'b1;
            state_q     <= FILL;
          end else if (|grant) begin
            s1_en_q   <= 1'b1;
            s1_addr_q <= sel_addr;
            s1_rgb_q  <= sel_rgb;
            ptr_q     <= next_ptr;
          end
        end
        FILL: begin
          if (cnt_q < count_q) begin
            s1_en_q   <= 1'b1;
            s1_addr_q <= cnt_q[ADDR_W-1:0];
            s1_rgb_q  <= fill_rgb_q;
            cnt_q     <= cnt_q + (ADDR_W+1)'(1);
          end
          // The counter is one bit wider than the address, so a full-buffer fill ends without wrapping.
          if ((cnt_q + (ADDR_W+1)'(1)) >= count_q) begin
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          fill_done_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          fill_busy_q <= 1'b0;
          fill_done_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;

`ifdef WS2812_BRIGHTNESS_EN
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  rgb_t              wr_rgb_q;

  // The scaling stage reads brightness at the moment each write passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_rgb_q  <= '0;
    end else begin
      wr_en_q <= s1_en_q;
      if (s1_en_q) begin
        wr_addr_q <= s1_addr_q;
        wr_rgb_q  <= scale_rgb(s1_rgb_q, brightness);
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_rgb  = wr_rgb_q;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;

  assign wr_en   = s1_en_q;
  assign wr_addr = s1_addr_q;
  assign wr_rgb  = s1_rgb_q;
`endif

endmodule

// File: tb/tb_ws2812_write_scheduler.sv
// Bench for ws2812_write_scheduler: a queue-based reference model checks every cycle,
// and directed scenarios pin literal values. Honours WS2812_BRIGHTNESS_EN.
module tb_ws2812_write_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
`ifdef WS2812_BRIGHTNESS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*24-1:0]     req_rgb;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fill_start;
  logic [23:0]               fill_rgb;
  logic [ADDR_W:0]           fill_count;
  logic                      fill_busy;
  logic                      fill_done;
  logic [7:0]                brightness;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [23:0]               wr_rgb;

  ws2812_write_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_rgb    (req_rgb),
    .req_ready  (req_ready),
    .fill_start (fill_start),
    .fill_rgb   (fill_rgb),
    .fill_count (fill_count),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .brightness (brightness),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_rgb     (wr_rgb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a list of pending writes, each with the cycle it must appear on the bus.
  typedef struct {
    int          due;
    logic [7:0]  addr;
    logic [23:0] rgb;
  } wr_t;

  wr_t          wq[$];
  wr_t          wtmp;
  int           mState = 0;
  int           mPtr   = 0;
  int           mNext  = 0;
  int           mCount = 0;
  int           gi;
  logic [23:0]  mFillRgb = '0;
  logic [3:0]   mGrant = '0;
  logic [3:0]   mLastGrant = '0;

  function automatic logic [23:0] expColour(input logic [23:0] c);
`ifdef WS2812_BRIGHTNESS_EN
    logic [23:0] r;
    for (int k = 0; k < 3; k++) r[k*8 +: 8] = 8'((int'(c[k*8 +: 8]) * (int'(brightness) + 1)) / 256);
    return r;
`else
    return c;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("rst_wr_rgb", 32'(wr_rgb), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_fill_busy", 32'(fill_busy), 32'd0);
      checkOutput("rst_fill_done", 32'(fill_done), 32'd0);
      wq.delete();
      mState = 0; mPtr = 0; mNext = 0; mCount = 0; mLastGrant = '0;
    end else begin
      mGrant = '0;
      if (mState == 0 && !fill_start) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          gi = (mPtr + k) % NUM_REQ;
          if (req_valid[gi] && mGrant == 4'd0) mGrant[gi] = 1'b1;
        end
      end
      checkOutput("req_ready", 32'(req_ready), 32'(mGrant));
      checkOutput("fill_busy", 32'(fill_busy), 32'(mState == 1));
      checkOutput("fill_done", 32'(fill_done), 32'(mState == 2));
      if (wq.size() > 0 && wq[0].due == cyc) begin
        wtmp = wq.pop_front();
        checkOutput("wr_en", 32'(wr_en), 32'd1);
        checkOutput("wr_addr", 32'(wr_addr), 32'(wtmp.addr));
        checkOutput("wr_rgb", 32'(wr_rgb), 32'(expColour(wtmp.rgb)));
      end else begin
        checkOutput("wr_en_idle", 32'(wr_en), 32'd0);
      end
      case (mState)
        0: begin
          if (fill_start) begin
            mFillRgb = fill_rgb; mCount = int'(fill_count); mNext = 0; mState = 1;
          end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
              if (mGrant[i]) begin
                wtmp.due = cyc + LAT; wtmp.addr = req_addr[i*8 +: 8]; wtmp.rgb = req_rgb[i*24 +: 24];
                wq.push_back(wtmp);
                mPtr = (i + 1) % NUM_REQ;
              end
            end
          end
        end
        1: begin
          if (mNext < mCount) begin
            wtmp.due = cyc + LAT; wtmp.addr = mNext[7:0]; wtmp.rgb = mFillRgb;
            wq.push_back(wtmp);
            mNext++;
          end
          if (mNext >= mCount) mState = 2;
        end
        default: mState = 0;
      endcase
      mLastGrant = mGrant;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [7:0] a, input logic [23:0] c);
    req_addr[i*8 +: 8] = a;
    req_rgb[i*24 +: 24] = c;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic fs, input logic [8:0] fc, input logic [23:0] fr);
    req_valid  = v;
    fill_start = fs;
    fill_count = fc;
    fill_rgb   = fr;
  endtask

  task automatic randomCycles(input int n);
    for (int c = 0; c < n; c++) begin
      nextCycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !mLastGrant[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          setReq(i, 8'($urandom), 24'($urandom));
        end
      end
      fill_start = ($urandom_range(0, 39) == 0);
      fill_count = ($urandom_range(0, 9) == 0) ? 9'd256 : 9'($urandom_range(0, 12));
      fill_rgb   = 24'($urandom);
    end
  endtask

  int nWr;
  int nDone;
  int tWr;

  initial begin
    rst_n = 1'b1;
    req_valid = '0; req_addr = '0; req_rgb = '0;
    fill_start = 1'b0; fill_rgb = '0; fill_count = '0;
    brightness = 8'd255;
    #2 rst_n = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    checkOutput("reset_ready_masked", 32'(req_ready), 32'd0);
    checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    req_valid = '0;

    $display("[TB] all four requesters valid: round-robin order");
    nextCycle();
    for (int i = 0; i < NUM_REQ; i++) setReq(i, 8'(8'h20 + i), 24'(24'h101010 * (i + 1)));
    applyStimulus(4'hF, 1'b0, 9'd0, 24'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= LAT) begin
        checkOutput("rr_wr_en", 32'(wr_en), 32'd1);
        checkOutput("rr_wr_addr", 32'(wr_addr), 32'(8'h20 + ((k - LAT) % 4)));
      end
      nextCycle();
    end
    req_valid = '0;
    repeat (4) nextCycle();

    $display("[TB] single requester 2");
    setReq(2, 8'h11, 24'hFF0000);
    req_valid = 4'b0100;
    @(negedge clk);
    checkOutput("solo_ready", 32'(req_ready), 32'h4);
    nextCycle();
    req_valid = '0;
    repeat (LAT - 1) nextCycle();
    @(negedge clk);
    checkOutput("solo_wr_en", 32'(wr_en), 32'd1);
    checkOutput("solo_wr_addr", 32'(wr_addr), 32'h11);
    checkOutput("solo_wr_rgb", 32'(wr_rgb), 32'hFF0000);
    repeat (3) nextCycle();

    $display("[TB] fill of 5 with requester 1 waiting");
    setReq(1, 8'h33, 24'h123456);
    applyStimulus(4'b0010, 1'b1, 9'd5, 24'h00FF00);
    @(negedge clk);
    checkOutput("fill5_ready_blocked", 32'(req_ready), 32'd0);
    for (int t = 1; t <= 7; t++) begin
      nextCycle();
      fill_start = 1'b0; fill_count = 9'd99; fill_rgb = 24'hABCDEF;
      @(negedge clk);
      checkOutput("fill5_busy", 32'(fill_busy), 32'(t <= 5));
      checkOutput("fill5_done", 32'(fill_done), 32'(t == 6));
      checkOutput("fill5_ready", 32'(req_ready), (t == 7) ? 32'h2 : 32'h0);
      if (t >= 1 + LAT && t <= 5 + LAT) begin
        checkOutput("fill5_wr_addr", 32'(wr_addr), 32'(t - 1 - LAT));
        checkOutput("fill5_wr_rgb", 32'(wr_rgb), 32'h00FF00);
      end
    end
    nextCycle();
    req_valid = '0;
    repeat (4) nextCycle();

    $display("[TB] fill of 0");
    applyStimulus(4'b0000, 1'b1, 9'd0, 24'h0000FF);
    nextCycle();
    fill_start = 1'b0;
    @(negedge clk);
    checkOutput("fill0_busy", 32'(fill_busy), 32'd1);
    checkOutput("fill0_wr_en", 32'(wr_en), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("fill0_done", 32'(fill_done), 32'd1);
    checkOutput("fill0_busy_low", 32'(fill_busy), 32'd0);
    repeat (3) nextCycle();

    $display("[TB] fill of 256");
    applyStimulus(4'b0000, 1'b1, 9'd256, 24'h445566);
    nextCycle();
    fill_start = 1'b0;
    nWr = 0; nDone = 0;
    repeat (300) begin
      @(negedge clk);
      if (wr_en) nWr++;
      if (fill_done) nDone++;
    end
    checkOutput("fill256_writes", 32'(nWr), 32'd256);
    checkOutput("fill256_done_pulses", 32'(nDone), 32'd1);
    nextCycle();

    $display("[TB] reset in the middle of a 200-pixel fill");
    applyStimulus(4'b0000, 1'b1, 9'd200, 24'h777777);
    nextCycle();
    fill_start = 1'b0;
    nWr = 0;
    for (tWr = 0; tWr < 300 && nWr < 50; tWr++) begin
      @(negedge clk);
      if (wr_en) nWr++;
    end
    checkOutput("midfill_reached_50", 32'(nWr), 32'd50);
    nextCycle();
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    checkOutput("midfill_rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("midfill_rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("midfill_rst_wr_rgb", 32'(wr_rgb), 32'd0);
    checkOutput("midfill_rst_busy", 32'(fill_busy), 32'd0);
    checkOutput("midfill_rst_done", 32'(fill_done), 32'd0);
    checkOutput("midfill_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    req_valid = '0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checkOutput("after_rst_busy", 32'(fill_busy), 32'd0);
      checkOutput("after_rst_done", 32'(fill_done), 32'd0);
      nextCycle();
    end

`ifdef WS2812_BRIGHTNESS_EN
    $display("[TB] brightness scaling");
    brightness = 8'd127;
    setReq(0, 8'h05, 24'hFF8040);
    req_valid = 4'b0001;
    nextCycle();
    req_valid = '0;
    nextCycle();
    @(negedge clk);
    checkOutput("bright127_wr_rgb", 32'(wr_rgb), 32'h7F4020);
    repeat (2) nextCycle();
    brightness = 8'd255;
    req_valid = 4'b0001;
    nextCycle();
    req_valid = '0;
    nextCycle();
    @(negedge clk);
    checkOutput("bright255_wr_rgb", 32'(wr_rgb), 32'hFF8040);
    repeat (2) nextCycle();
    brightness = 8'($urandom);
`endif

    $display("[TB] randomized traffic");
    randomCycles(1500);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 9'd0, 24'd0);
    repeat (300) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
